minmax_stream_loader: RTL and testbench
=======================================

# minmax_stream_loader

Producer-side companion to the min/max search engine. It buffers up to 16 host-written (address, value) pairs, replays them as a `s_vi`/`ai`/`di` write stream in ascending address order, then waits for the engine's `vo` and captures the max address, max value and min value into a host-facing result register. It sits between host control logic and the engine's stream input and result outputs.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles to wait in WAIT for `vo` before flagging an error; range 1..255, held in an 8-bit counter.

Ports, listed as name, direction, width, meaning:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `wr_en`, in, 1: host buffer write strobe; honoured only in IDLE.
- `wr_addr`, in, 4: buffer slot, which is also the stream address.
- `wr_data`, in, 5: value for the slot.
- `clr`, in, 1: clears every valid bit; honoured only in IDLE.
- `start`, in, 1: begins a run; honoured only in IDLE.
- `busy`, out, 1: high in SEND, WAIT and DONE.
- `s_vi`, out, 1: stream valid to the engine.
- `takein`, out, 1: engine enable; high in SEND and WAIT.
- `ai`, out, 4: stream address.
- `di`, out, 5: stream data.
- `vo`, in, 1: engine result valid.
- `ao_in`, in, 4: engine max address.
- `do_in`, in, 5: engine max value.
- `do_min_in`, in, 5: engine min value.
- `res_valid`, out, 1: one-cycle pulse when the result registers are updated.
- `res_err`, out, 1: set with `res_valid` on timeout or an empty run.
- `res_addr`, out, 4: captured max address.
- `res_max`, out, 5: captured max value.
- `res_min`, out, 5: captured min value.

## Operation
- Storage:
  - `mem[16]` holds 5-bit values.
  - `vmask[16]` holds one valid bit per slot.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - `wr_en` writes `mem[wr_addr]=wr_data` and sets `vmask[wr_addr]=1`. A rewrite of a slot overwrites it.
  - `clr` clears `vmask`. If `clr` and `wr_en` occur in the same cycle, `clr` applies first, so only the new slot remains valid.
  - `start` with `vmask!=0` goes to SEND with `ptr=0`.
  - `start` with `vmask==0` goes to DONE with `err=1`.
  - If `start` and `wr_en` occur in the same cycle, the write commits and is included in the run.
- SEND:
  - Exactly 16 cycles, `ptr` = 0..15.
  - Each cycle registers `s_vi=vmask[ptr]`, `ai=ptr`, `di=mem[ptr]`.
  - Invalid slots produce `s_vi=0`; `ai` and `di` still track `ptr`.
  - After `ptr=15`, go to WAIT and clear the timeout counter.
- WAIT:
  - `s_vi=0`.
  - When `vo=1`, capture `ao_in`, `do_in` and `do_min_in`, then go to DONE with `err=0`.
  - When the counter reaches `TIMEOUT` without `vo`, go to DONE with `err=1` and leave the result registers unchanged.
- DONE:
  - Lasts one cycle.
  - `res_valid=1` and `res_err=err`.
  - Next state is IDLE.
  - `vmask` and `mem` are retained, so `start` can re-run the same data set.
- Inputs ignored outside IDLE: `wr_en`, `clr` and `start` have no effect and are not queued.
- `vo` outside WAIT is ignored.

## Timing
- Reset value of every output is 0: `busy`, `s_vi`, `takein`, `ai`, `di`, `res_valid`, `res_err`, `res_addr`, `res_max`, `res_min`.
- Reset also clears `vmask`, `ptr`, the timeout counter and the FSM (to IDLE).
- All outputs are registered; there are no combinational input-to-output paths.
- Reset mid-run: on the reset edge, `s_vi` and `takein` drop to 0 and the FSM returns to IDLE.
- `start` sampled at edge E0:
  - `busy=1` from E0.
  - Slot k is presented on `s_vi`/`ai`/`di` between edges E0+k+1 and E0+k+2, and the engine samples it at E0+k+2.
  - The last slot is presented between edges E0+16 and E0+17.
  - WAIT begins at E0+17, where `s_vi` and `ai` return to 0.
- `vo` sampled high at edge Ev:
  - Result registers and `res_valid=1` appear after Ev.
  - `res_valid` drops after Ev+1, along with `busy` and `takein`.
- Minimum run length is 18 cycles from `start` to `res_valid`.
- Timeout:
  - `res_valid` with `res_err=1` appears `TIMEOUT`+1 edges after WAIT entry.
  - Example: with `TIMEOUT=3`, WAIT is entered at E0+17 and `res_valid` with `res_err=1` appears after E0+21.
- `res_addr`, `res_max` and `res_min` hold their values until the next successful capture or reset.

## Test plan
- Basic run: write (0,15), (15,28), (13,6), then `start`. Required response:
  - `s_vi` pulses at `ai`=0, 13, 15 with `di`=15, 6, 28, in that order.
  - The stub returns `vo` with `ao_in=15`, `do_in=28`, `do_min_in=6`.
  - Result: `res_valid=1`, `res_addr=15`, `res_max=28`, `res_min=6`, `res_err=0`.
- Empty start: `start` with no writes. Required response: `res_valid=1` and `res_err=1` after one cycle, with no `s_vi` pulse.
- Timeout: `TIMEOUT=3` and the stub never asserts `vo`. Required response:
  - `res_err=1` after E0+21.
  - Result registers keep their previous values.
- Ignored inputs: `wr_en`, `clr` and `start` pulsed during SEND. Required response:
  - Stream contents are unchanged.
  - After DONE, a re-run produces an identical stream.
- Same-cycle events: in IDLE, assert `clr` together with `wr_en` to slot 4 (value 9), then `start`. Required response: only `ai=4`, `di=9` carries `s_vi=1`.
- Reset mid-run: assert `rst` at E0+5. Required response:
  - `s_vi`, `takein` and `busy` are 0 after that edge.
  - A following `start` returns DONE with `res_err=1`, because `vmask` was cleared.

Source files
------------

// File: rtl/minmax_stream_loader.sv
// minmax_stream_loader
// Buffers up to 16 host-written (address, value) pairs and replays them to the
// min/max search engine as an s_vi/ai/di stream in ascending address order.
// It then waits for the engine's vo and latches the max address, max value and
// min value into a host-facing result register.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  host slot write (IDLE only)
//   clr                    host clear of all valid bits (IDLE only)
//   start                  host run request (IDLE only)
//   busy                   high while a run is in progress (SEND/WAIT/DONE)
//   s_vi/ai/di             stream to the engine
//   takein                 engine enable (SEND and WAIT)
//   vo/ao_in/do_in/do_min_in  engine result inputs
//   res_valid/res_err      one-cycle result pulse and error flag
//   res_addr/res_max/res_min  captured result, held until next capture
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | host may write/clear slots and start a run
// SEND  | 16 cycles, one slot per cycle, ptr = 0..15
// WAIT  | stream idle, waiting for vo or the timeout
// DONE  | one cycle, result pulse issued on entry, back to IDLE
module minmax_stream_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       clr,
  input  logic       start,
  output logic       busy,
  output logic       s_vi,
  output logic       takein,
  output logic [3:0] ai,
  output logic [4:0] di,
  input  logic       vo,
  input  logic [3:0] ao_in,
  input  logic [4:0] do_in,
  input  logic [4:0] do_min_in,
  output logic       res_valid,
  output logic       res_err,
  output logic [3:0] res_addr,
  output logic [4:0] res_max,
  output logic [4:0] res_min
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tc_q, tc_d;
  logic [15:0] vmask_q, vmask_d;
  logic [4:0]  mem_q [16];
  logic [4:0]  mem_d [16];

  logic        busy_q, busy_d;
  logic        s_vi_q, s_vi_d;
  logic        takein_q, takein_d;
  logic [3:0]  ai_q, ai_d;
  logic [4:0]  di_q, di_d;
  logic        res_valid_q, res_valid_d;
  logic        res_err_q, res_err_d;
  logic [3:0]  res_addr_q, res_addr_d;
  logic [4:0]  res_max_q, res_max_d;
  logic [4:0]  res_min_q, res_min_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tc_d        = 1'b0;
    vmask_d     = vmask_q;
    mem_d       = mem_q;
    res_valid_d = 1'b0;
    res_err_d   = 1'b0;
    res_addr_d  = res_addr_q;
    res_max_d   = res_max_q;
    res_min_d   = res_min_q;

    case (state_q)
      ST_IDLE: begin
        // clr lands before the write so a same-cycle write survives
        if (clr) vmask_d = '0;
        if (wr_en) begin
          mem_d[wr_addr]   = wr_data;
          vmask_d[wr_addr] = 1'b1;
        end
        // emptiness is judged after this cycle's clr/write
        if (start) begin
          if (vmask_d != '0) begin
            state_d = ST_SEND;
            ptr_d   = 4'd0;
          end else begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end
        end
      end
      ST_SEND: begin
        ptr_d = ptr_q + 4'd1;
        if (ptr_q == 4'd15) begin
          state_d = ST_WAIT;
          cnt_d   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (vo) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_addr_d  = ao_in;
          res_max_d   = do_in;
          res_min_d   = do_min_in;
        end else if (tc_q) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
        end else if (cnt_q == TMO) begin
          // terminal count is registered, giving TIMEOUT+1 idle cycles
          tc_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_vi_d   = (state_q == ST_SEND) ? vmask_q[ptr_q] : 1'b0;
    ai_d     = (state_q == ST_SEND) ? ptr_q : 4'd0;
    di_d     = (state_q == ST_SEND) ? mem_q[ptr_q] : 5'd0;
    takein_d = (state_q == ST_SEND) || (state_q == ST_WAIT);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 4'd0;
      cnt_q       <= 8'd0;
      tc_q        <= 1'b0;
      vmask_q     <= 16'd0;
      busy_q      <= 1'b0;
      s_vi_q      <= 1'b0;
      takein_q    <= 1'b0;
      ai_q        <= 4'd0;
      di_q        <= 5'd0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_addr_q  <= 4'd0;
      res_max_q   <= 5'd0;
      res_min_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tc_q        <= tc_d;
      vmask_q     <= vmask_d;
      busy_q      <= busy_d;
      s_vi_q      <= s_vi_d;
      takein_q    <= takein_d;
      ai_q        <= ai_d;
      di_q        <= di_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_addr_q  <= res_addr_d;
      res_max_q   <= res_max_d;
      res_min_q   <= res_min_d;
    end
  end

  // slot values are only meaningful under vmask, so they need no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy      = busy_q;
  assign s_vi      = s_vi_q;
  assign takein    = takein_q;
  assign ai        = ai_q;
  assign di        = di_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_addr  = res_addr_q;
  assign res_max   = res_max_q;
  assign res_min   = res_min_q;

endmodule

// File: tb/tb_minmax_stream_loader.sv
module tb_minmax_stream_loader;

  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [4:0] wr_data = 5'd0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       vo = 1'b0;
  logic [3:0] ao_in = 4'd0;
  logic [4:0] do_in = 5'd0;
  logic [4:0] do_min_in = 5'd0;
  logic       busy, s_vi, takein, res_valid, res_err;
  logic [3:0] ai, res_addr;
  logic [4:0] di, res_max, res_min;

  minmax_stream_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .start(start), .busy(busy), .s_vi(s_vi), .takein(takein),
    .ai(ai), .di(di), .vo(vo), .ao_in(ao_in), .do_in(do_in),
    .do_min_in(do_min_in), .res_valid(res_valid), .res_err(res_err),
    .res_addr(res_addr), .res_max(res_max), .res_min(res_min)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int cyc; logic [3:0] a; logic [4:0] d;} strm_t;
  typedef struct {logic err; logic [3:0] a; logic [4:0] mx; logic [4:0] mn;} res_t;
  strm_t sq[$];
  res_t  rq[$];
  strm_t se;
  res_t  re;

  // reference model of the host-visible state
  logic [4:0]  m_mem [16];
  logic [15:0] m_vmask = 16'd0;
  logic [3:0]  m_addr = 4'd0;
  logic [4:0]  m_max = 5'd0;
  logic [4:0]  m_min = 5'd0;

  always @(negedge clk) begin
    if (s_vi === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected got ai=%0d di=%0d at cyc %0d, none expected", ai, di, cyc);
      end else begin
        se = sq.pop_front();
        if (ai !== se.a || di !== se.d || cyc != se.cyc) begin
          errors++;
          $display("FAIL stream_item got ai=%0d di=%0d cyc=%0d exp ai=%0d di=%0d cyc=%0d",
                   ai, di, cyc, se.a, se.d, se.cyc);
        end
      end
    end
    if (res_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got err=%b addr=%0d max=%0d min=%0d", res_err, res_addr, res_max, res_min);
      end else begin
        re = rq.pop_front();
        if (res_err !== re.err || res_addr !== re.a || res_max !== re.mx || res_min !== re.mn) begin
          errors++;
          $display("FAIL result_fields got err=%b addr=%0d max=%0d min=%0d exp err=%b addr=%0d max=%0d min=%0d",
                   res_err, res_addr, res_max, res_min, re.err, re.a, re.mx, re.mn);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_vmask = 16'd0;
    m_addr  = 4'd0;
    m_max   = 5'd0;
    m_min   = 5'd0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [4:0] d, input logic with_clr);
    wr_en = 1'b1; wr_addr = a; wr_data = d; clr = with_clr;
    step();
    wr_en = 1'b0; clr = 1'b0;
    if (with_clr) m_vmask = 16'd0;
    m_vmask[a] = 1'b1;
    m_mem[a] = d;
  endtask

  // expected stream for a start applied now; slot k shows at cyc+k+2
  task automatic push_stream(input int maxk);
    for (int k = 0; k <= maxk; k++)
      if (m_vmask[k]) sq.push_back('{cyc + k + 2, 4'(k), m_mem[k]});
  endtask

  task automatic run(input bit give_vo, input int vo_wait, input logic [3:0] a,
                     input logic [4:0] mx, input logic [4:0] mn, input bit ign);
    int c0;
    int n;
    if (m_vmask == 16'd0) begin
      rq.push_back('{1'b1, m_addr, m_max, m_min});
      start = 1'b1;
      step();
      start = 1'b0; wr_en = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_err !== 1'b1 || busy !== 1'b1 || takein !== 1'b0) begin
        errors++;
        $display("FAIL empty_start got valid=%b err=%b busy=%b takein=%b exp 1 1 1 0", res_valid, res_err, busy, takein);
      end
      step();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty_done got valid=%b busy=%b exp 0 0", res_valid, busy);
      end
      return;
    end
    push_stream(15);
    start = 1'b1;
    step();
    start = 1'b0; wr_en = 1'b0;
    c0 = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b exp 1", busy);
    end
    for (int i = 1; i <= 16; i++) begin
      if (ign) begin
        case (i)
          3: begin wr_en = 1'b1; wr_addr = 4'd2; wr_data = 5'd3; end
          5: clr = 1'b1;
          7: start = 1'b1;
          9: begin vo = 1'b1; ao_in = 4'd1; do_in = 5'd1; do_min_in = 5'd1; end
          default: ;
        endcase
      end
      step();
      wr_en = 1'b0; clr = 1'b0; start = 1'b0; vo = 1'b0;
    end
    checks++;
    if (takein !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL send_flags got takein=%b busy=%b exp 1 1", takein, busy);
    end
    step();
    checks++;
    if (s_vi !== 1'b0 || ai !== 4'd0 || takein !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry got s_vi=%b ai=%0d takein=%b busy=%b exp 0 0 1 1", s_vi, ai, takein, busy);
    end
    if (give_vo) begin
      repeat (vo_wait) step();
      vo = 1'b1; ao_in = a; do_in = mx; do_min_in = mn;
      rq.push_back('{1'b0, a, mx, mn});
      m_addr = a; m_max = mx; m_min = mn;
      step();
      vo = 1'b0; ao_in = 4'd0; do_in = 5'd0; do_min_in = 5'd0;
      checks++;
      if (res_valid !== 1'b1 || res_err !== 1'b0 || res_addr !== a || res_max !== mx ||
          res_min !== mn || busy !== 1'b1 || takein !== 1'b1) begin
        errors++;
        $display("FAIL vo_capture got valid=%b err=%b addr=%0d max=%0d min=%0d busy=%b takein=%b exp 1 0 %0d %0d %0d 1 1",
                 res_valid, res_err, res_addr, res_max, res_min, busy, takein, a, mx, mn);
      end
      step();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || takein !== 1'b0) begin
        errors++;
        $display("FAIL after_done got valid=%b busy=%b takein=%b exp 0 0 0", res_valid, busy, takein);
      end
    end else begin
      rq.push_back('{1'b1, m_addr, m_max, m_min});
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      checks++;
      if (res_valid !== 1'b1) begin
        errors++;
        $display("FAIL timeout_result got no res_valid within 40 cycles exp one");
      end else if (cyc != c0 + 17 + TMO + 1 || res_err !== 1'b1) begin
        errors++;
        $display("FAIL timeout_timing got cyc=%0d err=%b exp cyc=%0d err=1", cyc, res_err, c0 + 17 + TMO + 1);
      end
      checks++;
      if (res_addr !== m_addr || res_max !== m_max || res_min !== m_min) begin
        errors++;
        $display("FAIL timeout_hold got addr=%0d max=%0d min=%0d exp %0d %0d %0d",
                 res_addr, res_max, res_min, m_addr, m_max, m_min);
      end
      step();
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got stream=%0d results=%0d pending exp 0 0", name, sq.size(), rq.size());
      sq.delete();
      rq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if ({busy, s_vi, takein, ai, di, res_valid, res_err, res_addr, res_max, res_min} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b s_vi=%b takein=%b ai=%0d di=%0d valid=%b err=%b addr=%0d max=%0d min=%0d exp all 0",
               busy, s_vi, takein, ai, di, res_valid, res_err, res_addr, res_max, res_min);
    end
  endtask

  task automatic test_empty_start();
    run(1'b0, 0, 4'd0, 5'd0, 5'd0, 1'b0);
    check_drained("empty");
  endtask

  task automatic test_basic();
    host_write(4'd0, 5'd15, 1'b0);
    host_write(4'd15, 5'd28, 1'b0);
    host_write(4'd13, 5'd6, 1'b0);
    run(1'b1, 1, 4'd15, 5'd28, 5'd6, 1'b0);
    check_drained("basic");
  endtask

  task automatic test_timeout();
    run(1'b0, 0, 4'd0, 5'd0, 5'd0, 1'b0);
    check_drained("timeout");
  endtask

  task automatic test_ignored_inputs();
    run(1'b1, 0, 4'd13, 5'd27, 5'd2, 1'b1);
    run(1'b1, 2, 4'd0, 5'd31, 5'd0, 1'b0);
    check_drained("ignored");
  endtask

  task automatic test_same_cycle();
    host_write(4'd4, 5'd9, 1'b1);
    run(1'b1, 1, 4'd4, 5'd9, 5'd9, 1'b0);
    // write committed on the start edge joins the run
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 5'd2;
    m_vmask[7] = 1'b1; m_mem[7] = 5'd2;
    run(1'b1, 0, 4'd4, 5'd9, 5'd2, 1'b0);
    check_drained("same_cycle");
  endtask

  task automatic test_reset_mid_run();
    host_write(4'd2, 5'd17, 1'b0);
    push_stream(3);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (s_vi !== 1'b0 || takein !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got s_vi=%b takein=%b busy=%b exp 0 0 0", s_vi, takein, busy);
    end
    check_drained("reset_mid");
    run(1'b0, 0, 4'd0, 5'd0, 5'd0, 1'b0);
    check_drained("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_start();
    test_basic();
    test_timeout();
    test_ignored_inputs();
    test_same_cycle();
    test_reset_mid_run();
    step();
    check_drained("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
